// File: rtl/w5500_spi_responder.sv
// W5500-style SPI slave (mode 3, MSB first) fronting a simple register bus.
// Frame: 16-bit address, control byte {bsb[4:0], rwb, om[1:0]}, then data.
// All SPI pins are oversampled in the clk domain; clk must be >= 8x sck.
module w5500_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sck,
    input  logic        mosi,
    input  logic        SCSn,
    output logic        miso,
    output logic [15:0] reg_addr,
    output logic [4:0]  reg_bsb,
    output logic        wr_en,
    output logic [7:0]  wr_data,
    output logic        rd_req,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);
    typedef enum logic [2:0] {IDLE, ADDR, CTRL, DATA, HOLD} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic        sck_d, cs_d;
    logic        sck_s, mosi_s, cs_s;
    logic        sck_rise, sck_fall, cs_rise, cs_fall;
    logic        rise_ok, byte_end, last_byte;
    logic        frame_ok, frame_bad;
    logic [2:0]  bit_cnt, byte_cnt, n_bytes;
    logic        addr_hi;            // second address byte in progress
    logic [14:0] rx_shift;
    logic [15:0] rx_next;
    logic [7:0]  tx_shift;
    logic        rwb;
    logic [1:0]  om;
    logic        ld_pend, inc_pend, pf_pend;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign cs_rise  = cs_s & ~cs_d;
    assign cs_fall  = ~cs_s & cs_d;
    // chip-select release beats a coincident sck rise
    assign rise_ok  = sck_rise & ~cs_rise;
    assign byte_end = rise_ok && (bit_cnt == 3'd7);
    assign rx_next  = {rx_shift, mosi_s};

    // Input synchronizers; sck and SCSn reset to their idle-high level so
    // reset release never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync  <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b1;
            cs_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SCSn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
            cs_d      <= cs_s;
        end
    end

    // Fixed-length byte count from the operation mode (0 = variable).
    always_comb begin
        case (om)
            2'b01:   n_bytes = 3'd1;
            2'b10:   n_bytes = 3'd2;
            2'b11:   n_bytes = 3'd4;
            default: n_bytes = 3'd0;
        endcase
    end

    // Next-state logic plus end-of-frame classification.
    always_comb begin
        state_d   = state_q;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        last_byte = (om != 2'b00) && ((byte_cnt + 3'd1) == n_bytes);
        case (state_q)
            IDLE: if (cs_fall) state_d = ADDR;
            ADDR: if (byte_end && addr_hi) state_d = CTRL;
            CTRL: if (byte_end) state_d = DATA;
            DATA: if (byte_end && last_byte) state_d = HOLD;
            default: ;
        endcase
        if (cs_rise && state_q != IDLE) begin
            state_d = IDLE;
            if ((state_q == DATA || state_q == HOLD) && bit_cnt == 3'd0 &&
                (om == 2'b00 || byte_cnt >= n_bytes))
                frame_ok = 1'b1;
            else
                frame_bad = 1'b1;
        end
    end

    // State register, shift registers, counters and bus strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            miso       <= 1'b0;
            reg_addr   <= '0;
            reg_bsb    <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            rd_req     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            addr_hi    <= 1'b0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            rwb        <= 1'b0;
            om         <= '0;
            ld_pend    <= 1'b0;
            inc_pend   <= 1'b0;
            pf_pend    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_en      <= 1'b0;
            rd_req     <= 1'b0;
            frame_done <= frame_ok;
            frame_err  <= frame_bad;
            inc_pend   <= 1'b0;
            pf_pend    <= 1'b0;
            ld_pend    <= rd_req;
            if (inc_pend) reg_addr <= reg_addr + 16'd1;
            if (pf_pend && state_q == DATA) rd_req <= 1'b1;
            if (rise_ok && (state_q == ADDR || state_q == CTRL || state_q == DATA)) begin
                rx_shift <= rx_next[14:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end
            case (state_q)
                IDLE: if (cs_fall) begin
                    busy     <= 1'b1;
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    addr_hi  <= 1'b0;
                    miso     <= 1'b0;
                end
                ADDR: if (byte_end) begin
                    addr_hi <= ~addr_hi;
                    if (addr_hi) reg_addr <= rx_next;
                end
                CTRL: if (byte_end) begin
                    reg_bsb <= rx_next[7:3];
                    rwb     <= rx_next[2];
                    om      <= rx_next[1:0];
                    if (!rx_next[2]) rd_req <= 1'b1;
                end
                DATA: begin
                    if (sck_fall && !rwb) begin
                        miso     <= tx_shift[7];
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                    if (byte_end) begin
                        if (byte_cnt != 3'd4) byte_cnt <= byte_cnt + 3'd1;
                        if (rwb) begin
                            wr_en    <= 1'b1;
                            wr_data  <= rx_next[7:0];
                            inc_pend <= 1'b1;
                        end else begin
                            reg_addr <= reg_addr + 16'd1;
                            if (!last_byte) pf_pend <= 1'b1;
                        end
                    end
                    if (state_d == HOLD) miso <= 1'b0;
                end
                default: ;
            endcase
            // read data arrives one clk after rd_req
            if (ld_pend) tx_shift <= rd_data;
            if (cs_rise && state_q != IDLE) begin
                busy <= 1'b0;
                miso <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_w5500_spi_responder.sv
// Randomized frame-level bench: an SPI master drives frames, a register
// model answers reads, and expected bus traffic is computed per frame.
module tb_w5500_spi_responder;
    localparam int HALF = 8;   // clk cycles per sck half period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b1;
    logic        mosi = 1'b0;
    logic        SCSn = 1'b1;
    logic        miso;
    logic [15:0] reg_addr;
    logic [4:0]  reg_bsb;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        rd_req;
    logic [7:0]  rd_data = 8'h00;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    w5500_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sck(sck), .mosi(mosi), .SCSn(SCSn),
        .miso(miso), .reg_addr(reg_addr), .reg_bsb(reg_bsb),
        .wr_en(wr_en), .wr_data(wr_data), .rd_req(rd_req), .rd_data(rd_data),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0]  mem [0:65535];
    logic [7:0]  wbytes [0:7];
    logic [7:0]  rxb [0:7];
    logic [28:0] wq[$];     // {bsb, addr, data}
    logic [20:0] rq[$];     // {bsb, addr}
    int done_cnt, err_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bus observer and register model, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en)      wq.push_back({reg_bsb, reg_addr, wr_data});
        if (rd_req) begin
            rq.push_back({reg_bsb, reg_addr});
            rd_data = mem[reg_addr];
        end
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".miso"},  32'(miso), 0);
        chk({tag, ".addr"},  32'(reg_addr), 0);
        chk({tag, ".bsb"},   32'(reg_bsb), 0);
        chk({tag, ".wr"},    {23'd0, wr_en, wr_data}, 0);
        chk({tag, ".rdreq"}, 32'(rd_req), 0);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".ends"},  {30'd0, frame_done, frame_err}, 0);
    endtask

    // One sck cycle: drive on the falling edge, sample miso just before rising.
    task automatic spi_bit(input logic v, output logic m);
        sck = 1'b0;
        mosi = v;
        repeat (HALF) @(negedge clk);
        m = miso;
        sck = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Run one frame and check it against the frame-level model.
    // hdr_bits < 24 aborts inside the header.
    task automatic run_frame(input string tag, input logic [15:0] addr, input logic [4:0] bsb,
                             input logic wr, input logic [1:0] om,
                             input int nfull, input int npart, input int hdr_bits);
        logic [7:0] ctrl;
        logic       m, v;
        int total, db, n_om, served, nreq;
        logic       done_exp;
        logic [15:0] a;
        ctrl = {bsb, wr, om};
        total = (hdr_bits < 24) ? hdr_bits : 24 + 8 * nfull + npart;
        wq.delete(); rq.delete(); done_cnt = 0; err_cnt = 0;
        for (int i = 0; i < 8; i++) rxb[i] = 8'h00;
        SCSn = 1'b0;
        repeat (6) @(negedge clk);
        for (int b = 0; b < total; b++) begin
            if (b < 16)      v = addr[15 - b];
            else if (b < 24) v = ctrl[23 - b];
            else if (wr)     v = wbytes[(b - 24) / 8][7 - (b - 24) % 8];
            else             v = 1'($urandom_range(0, 1));
            spi_bit(v, m);
            if (b >= 24) begin
                db = (b - 24) / 8;
                rxb[db] = {rxb[db][6:0], m};
            end
        end
        repeat (HALF) @(negedge clk);
        SCSn = 1'b1;
        repeat (12) @(negedge clk);

        n_om   = (om == 2'd1) ? 1 : (om == 2'd2) ? 2 : (om == 2'd3) ? 4 : 0;
        served = (hdr_bits < 24) ? 0 : (om == 2'd0) ? nfull : (nfull < n_om ? nfull : n_om);
        done_exp = (hdr_bits >= 24) &&
                   ((om != 2'd0 && nfull >= n_om) || (om == 2'd0 && npart == 0));
        if (wr || hdr_bits < 24) nreq = 0;
        else if (om != 2'd0 && nfull >= n_om) nreq = n_om;
        else nreq = nfull + 1;

        chk({tag, ".done"}, done_cnt, done_exp ? 1 : 0);
        chk({tag, ".err"},  err_cnt,  done_exp ? 0 : 1);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".miso"}, 32'(miso), 0);
        chk({tag, ".nwr"},  wq.size(), wr ? served : 0);
        chk({tag, ".nrd"},  rq.size(), nreq);
        for (int i = 0; i < wq.size() && i < served; i++) begin
            a = addr + 16'(i);
            chk({tag, ".wr"}, 32'(wq[i]), 32'({bsb, a, wbytes[i]}));
        end
        for (int i = 0; i < rq.size() && i < nreq; i++) begin
            a = addr + 16'(i);
            chk({tag, ".rd"}, 32'(rq[i]), 32'({bsb, a}));
        end
        if (!wr && hdr_bits >= 24)
            for (int i = 0; i < nfull; i++) begin
                a = addr + 16'(i);
                chk({tag, ".miso_byte"}, 32'(rxb[i]), (i < served) ? 32'(mem[a]) : 0);
            end
    endtask

    initial begin
        logic m;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[3] = 8'h12;
        mem[4] = 8'h34;
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single-byte write
        wbytes[0] = 8'hA5;
        run_frame("t1", 16'h0001, 5'd0, 1'b1, 2'b01, 1, 0, 24);
        // 2: two-byte read
        run_frame("t2", 16'h0003, 5'd0, 1'b0, 2'b10, 2, 0, 24);
        chk("t2.word", {rxb[0], rxb[1]}, 32'h1234);
        // 3: variable-length write across address wrap
        wbytes[0] = 8'h11; wbytes[1] = 8'h22; wbytes[2] = 8'h33;
        run_frame("t3", 16'hFFFF, 5'd1, 1'b1, 2'b00, 3, 0, 24);
        // 4: abort after 4 data bits
        run_frame("t4", 16'h0040, 5'd2, 1'b1, 2'b00, 0, 4, 24);
        // 5: fixed one-byte write overclocked with a second byte
        wbytes[0] = 8'h5A; wbytes[1] = 8'hC3;
        run_frame("t5", 16'h0010, 5'd0, 1'b1, 2'b01, 2, 0, 24);

        // 6: reset during the control byte, then a clean frame
        done_cnt = 0; err_cnt = 0;
        SCSn = 1'b0;
        repeat (6) @(negedge clk);
        for (int b = 0; b < 19; b++) spi_bit((b == 3 || b == 10 || b == 13), m);
        rst = 1'b1;
        #1;
        chk_idle_outputs("t6.rst");
        SCSn = 1'b1;
        sck = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6.noend", done_cnt + err_cnt, 0);
        wbytes[0] = 8'hA5;
        run_frame("t6", 16'h0001, 5'd0, 1'b1, 2'b01, 1, 0, 24);

        // randomized frames
        for (int k = 0; k < 20; k++) begin
            logic [15:0] ra;
            for (int i = 0; i < 8; i++) wbytes[i] = 8'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            run_frame("rnd", ra, 5'($urandom), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), $urandom_range(0, 5),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0,
                      ($urandom_range(0, 7) == 0) ? $urandom_range(1, 23) : 24);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/w5500_spi_responder.md
Name: w5500_spi_responder

Overview:
- SPI slave that models the W5500 frame protocol on the far side of our SPI master.
- Used as a bench and loopback target for the master, and as a front end for an on-chip W5500-compatible register file.
- Decodes the frame: 16-bit address, 8-bit control byte, then data bytes. It issues write strobes and read requests to a simple register bus and shifts read data back on miso.
- All SPI inputs are oversampled in the single clk domain. clk must be at least 8x the sck frequency; the system runs at 500x.

Parameters:
SYNC_STAGES, 2, synchronizer flops on sck/mosi/SCSn (min 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
sck  input  1  SPI clock from master; idles high
mosi  input  1  SPI data from master
SCSn  input  1  chip select, active-low
miso  output  1  SPI data to master
reg_addr  output  16  current register address
reg_bsb  output  5  block select from control byte [7:3]
wr_en  output  1  one-clk write strobe
wr_data  output  8  write byte; valid with wr_en
rd_req  output  1  one-clk read request for reg_addr/reg_bsb
rd_data  input  8  read byte; must be valid exactly 1 clk after rd_req
busy  output  1  high while SCSn is low (synchronized)
frame_done  output  1  one-clk pulse on clean frame end
frame_err  output  1  one-clk pulse on malformed frame end

Behaviour:
- Reset values: miso=0, reg_addr=0, reg_bsb=0, wr_en=0, wr_data=0, rd_req=0, busy=0, frame_done=0, frame_err=0. FSM goes to IDLE and all counters clear. Reset acts immediately, including mid-frame.
- Synchronization: each input passes through SYNC_STAGES flops.
  - sck_rise and sck_fall are detected on the synchronized sck.
  - mosi is sampled on sck_rise (mode 3, MSB first).
  - miso changes only on sck_fall, within SYNC_STAGES+2 clk of the pin edge.
- FSM states: IDLE, ADDR, CTRL, DATA, HOLD.
  - IDLE -> ADDR on synchronized SCSn falling. busy=1 and the bit counter clears.
  - ADDR: shifts 16 bits. After the 16th rise, reg_addr is loaded from the shifted value. -> CTRL.
  - CTRL: shifts 8 bits. After the 8th rise, reg_bsb=ctrl[7:3], RWB=ctrl[2], OM=ctrl[1:0]. -> DATA.
    - If RWB=0 (read): rd_req pulses in the same clk as the transition.
    - rd_data is captured into the tx shift register the next clk.
  - OM decode: 00 = variable length, bounded only by SCSn; 01 = 1 byte; 10 = 2 bytes; 11 = 4 bytes.
  - DATA, write (RWB=1):
    - On each 8th rise, wr_en pulses for 1 clk with wr_data = the received byte and reg_addr = that byte's address.
    - reg_addr increments the following clk, wrapping 0xFFFF -> 0x0000.
  - DATA, read (RWB=0):
    - miso = tx_shift[7] on each sck_fall, then shift left.
    - On each 8th rise, reg_addr increments (same wrap) and rd_req pulses one clk later as a prefetch. The new byte loads 1 clk after that, before the next fall.
    - No prefetch after the final byte of a fixed-length frame.
  - In fixed modes, after N bytes -> HOLD.
  - HOLD: ignores sck and mosi. miso=0. No wr_en and no rd_req.
- miso is 0 in IDLE, ADDR, CTRL and HOLD. It returns to 0 one clk after synchronized SCSn goes high.
- On synchronized SCSn rising, from any state other than IDLE, the FSM returns to IDLE and busy=0.
  - frame_done pulses if the state was DATA or HOLD with bit counter = 0 and, for fixed OM, all N bytes done.
  - Otherwise frame_err pulses. Causes: ended in ADDR or CTRL, partial byte, or short fixed frame.
  - A partial write byte is discarded (no wr_en).
- Simultaneous events: if SCSn rising and sck_rise are detected in the same clk, SCSn wins and the bit is discarded.
- sck edges while SCSn is high are ignored.
- Bit counter is 3 bits. Byte counter is 3 bits and saturates at 4, used for fixed modes only.

Test Plan:
1. Write, OM=01: frame 0x0001, ctrl 0x05, data 0xA5 -> one wr_en with reg_addr=0x0001, reg_bsb=0, wr_data=0xA5; then frame_done; frame_err=0.
2. Read, OM=10: frame 0x0003, ctrl 0x02; model returns 0x12 at 0x0003 and 0x34 at 0x0004 -> master receives 0x1234; exactly 2 rd_req (addr 0x0003, 0x0004); frame_done.
3. Variable-length write with wrap: frame 0xFFFF, ctrl 0x0C, bytes 0x11 0x22 0x33 -> wr_en at 0xFFFF, 0x0000, 0x0001 with matching data; reg_bsb=0x01; frame_done.
4. Abort mid-byte: write frame OM=00, SCSn raised after 4 data bits -> no wr_en for the partial byte; frame_err pulse; FSM in IDLE; miso=0.
5. Fixed-mode overflow: OM=01 write clocking 2 data bytes -> only 1 wr_en; HOLD ignores the 2nd byte; frame_done (not frame_err) at SCSn high.
6. Reset mid-frame: assert rst during the CTRL phase, release, then run scenario 1 -> all outputs return to reset values immediately; the following frame decodes correctly.
